axi_rr_arbiter_nm: RTL and testbench

//  Parametrised round-robin arbiter for the AXI interconnect; selects one of NUM_M masters per address channel.

---
 rtl/axi_rr_arbiter_nm.sv | 138 +++++++++++++
 tb/tb_axi_rr_arbiter_nm.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arbiter_nm.sv
// Round-robin address-channel arbiter for NUM_M masters with a grant locked until handshake.
// Optional urgent-request override is enabled by defining ARB_QOS_EN.
module axi_rr_arbiter_nm #(
  parameter  int NUM_M = 3,
  localparam int IDW   = $clog2(NUM_M)
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             HandShake,
  input  logic [NUM_M-1:0] VALID_NM,
`ifdef ARB_QOS_EN
  input  logic [NUM_M-1:0] URGENT_NM,
`endif
  output logic [NUM_M-1:0] grant_out,
  output logic [IDW-1:0]   grant_id,
  output logic             busy
);

  // state | meaning
  // IDLE  | arbitrating combinationally; a winner is granted in the same cycle
  // LOCK  | grant held in r_grant_q until HandShake, requests ignored
  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [IDW-1:0] LAST  = IDW'(NUM_M - 1);
  localparam logic [IDW:0]   NUM_W = (IDW + 1)'(NUM_M);

  state_t           r_state;
  logic [NUM_M-1:0] r_grant_q;
  logic [IDW-1:0]   r_ptr;

  logic [NUM_M-1:0] w_req;
  logic [NUM_M-1:0] w_rot;
  logic             w_any;
  logic [IDW-1:0]   w_off;
  logic [IDW:0]     w_sum;
  logic [IDW-1:0]   w_win_idx;
  logic [NUM_M-1:0] w_win_oh;
  logic [IDW-1:0]   w_lock_idx;

  function automatic logic [IDW-1:0] f_inc(input logic [IDW-1:0] i);
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

`ifdef ARB_QOS_EN
  // Urgent requesters, when present, are the only candidates for this round.
  always_comb begin
    w_req = VALID_NM;
    if ((VALID_NM & URGENT_NM) != '0)
      w_req = VALID_NM & URGENT_NM;
  end
`else
  assign w_req = VALID_NM;
`endif

  // Rotate so bit 0 is the pointer master, then take the lowest set bit.
  assign w_rot = NUM_M'({w_req, w_req} >> r_ptr);

  always_comb begin
    w_any = 1'b0;
    w_off = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_any = 1'b1;
        w_off = IDW'(i);
      end
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win_idx = (w_sum >= NUM_W) ? IDW'(w_sum - NUM_W) : w_sum[IDW-1:0];
  assign w_win_oh  = {{(NUM_M-1){1'b0}}, 1'b1} << w_win_idx;

  always_comb begin
    w_lock_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_grant_q[i])
        w_lock_idx = w_lock_idx | IDW'(i);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= IDLE;
      r_grant_q <= '0;
      r_ptr     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            if (HandShake) begin
              r_ptr <= f_inc(w_win_idx);
            end else begin
              r_grant_q <= w_win_oh;
              r_state   <= LOCK;
            end
          end
        end
        LOCK: begin
          if (HandShake) begin
            r_state   <= IDLE;
            r_ptr     <= f_inc(w_lock_idx);
            r_grant_q <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reset gates the outputs so requests never leak through while ARESETn is low.
  always_comb begin
    grant_out = '0;
    if (ARESETn) begin
      if (r_state == LOCK)
        grant_out = r_grant_q;
      else if (w_any)
        grant_out = w_win_oh;
    end
  end

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_out[i])
        grant_id = grant_id | IDW'(i);
    end
  end

  assign busy = ARESETn && (r_state == LOCK);

  a_hs_without_req: assert property (@(posedge ACLK) disable iff (!ARESETn)
    !(r_state == IDLE && HandShake && VALID_NM == '0));
  a_grant_onehot: assert property (@(posedge ACLK) disable iff (!ARESETn)
    $onehot0(grant_out));
  a_ptr_range: assert property (@(posedge ACLK) disable iff (!ARESETn)
    r_ptr <= LAST);

endmodule

// File: tb/tb_axi_rr_arbiter_nm.sv
// Bench for axi_rr_arbiter_nm: a 3-master and an 8-master instance driven side by side,
// checked against a queue-free arithmetic round-robin model.
module tb_axi_rr_arbiter_nm;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic       HS3, HS8;
  logic [2:0] V3, U3;
  logic [7:0] V8, U8;
  logic [2:0] G3;
  logic [1:0] ID3;
  logic       B3;
  logic [7:0] G8;
  logic [2:0] ID8;
  logic       B8;

  always #5 ACLK = ~ACLK;

  axi_rr_arbiter_nm #(.NUM_M(3)) u_arb3 (
    .ACLK(ACLK), .ARESETn(ARESETn), .HandShake(HS3), .VALID_NM(V3),
`ifdef ARB_QOS_EN
    .URGENT_NM(U3),
`endif
    .grant_out(G3), .grant_id(ID3), .busy(B3)
  );

  axi_rr_arbiter_nm #(.NUM_M(8)) u_arb8 (
    .ACLK(ACLK), .ARESETn(ARESETn), .HandShake(HS8), .VALID_NM(V8),
`ifdef ARB_QOS_EN
    .URGENT_NM(U8),
`endif
    .grant_out(G8), .grant_id(ID8), .busy(B8)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model state per instance: 0 -> NUM_M=3, 1 -> NUM_M=8
  int NM[2] = '{3, 8};
  int m_ptr[2];
  int m_lk[2];
  int m_lm[2];

  function automatic int pick(input int n, input int p, input logic [7:0] v, input logic [7:0] u);
    logic [7:0] req;
    req = v;
`ifdef ARB_QOS_EN
    if ((v & u) != 8'h00) req = v & u;
`else
    if (u == 8'hxx) req = v;
`endif
    for (int k = 0; k < n; k++) begin
      int m;
      m = (p + k) % n;
      if (req[m]) return m;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0;
      m_lk[i]  = 0;
      m_lm[i]  = 0;
    end
  endtask

  task automatic model_check(input int i, input logic [7:0] v, input logic [7:0] u,
                             input logic [7:0] g, input int id, input logic b);
    int w;
    logic [7:0] eg;
    w  = m_lk[i] ? m_lm[i] : pick(NM[i], m_ptr[i], v, u);
    eg = (w < 0) ? 8'h00 : 8'(1 << w);
    chk($sformatf("n%0d_grant", NM[i]), 32'(g), 32'(eg));
    chk($sformatf("n%0d_id", NM[i]), 32'(id), (w < 0) ? 32'd0 : 32'(w));
    chk($sformatf("n%0d_busy", NM[i]), 32'(b), 32'(m_lk[i] != 0));
  endtask

  task automatic model_step(input int i, input logic [7:0] v, input logic [7:0] u, input logic hs);
    int w;
    if (m_lk[i] != 0) begin
      if (hs) begin
        m_lk[i]  = 0;
        m_ptr[i] = (m_lm[i] + 1) % NM[i];
      end
    end else begin
      w = pick(NM[i], m_ptr[i], v, u);
      if (w >= 0) begin
        if (hs) m_ptr[i] = (w + 1) % NM[i];
        else begin
          m_lk[i] = 1;
          m_lm[i] = w;
        end
      end
    end
  endtask

  // One clock: drive at negedge, check just after, let the DUT clock, advance the model.
  task automatic cycle(input logic [7:0] lv3, input logic [7:0] lu3, input logic lh3,
                       input logic [7:0] lv8, input logic [7:0] lu8, input logic lh8,
                       input int e3, input int e8);
    @(negedge ACLK);
    V3 = lv3[2:0]; U3 = lu3[2:0]; HS3 = lh3;
    V8 = lv8;      U8 = lu8;      HS8 = lh8;
    #1;
    model_check(0, {5'd0, V3}, {5'd0, U3}, {5'd0, G3}, int'(ID3), B3);
    model_check(1, V8, U8, G8, int'(ID8), B8);
    if (e3 >= 0) chk("n3_directed", 32'(G3), 32'(e3));
    if (e8 >= 0) chk("n8_directed", 32'(G8), 32'(e8));
    @(posedge ACLK);
    model_step(0, {5'd0, lv3[2:0]}, {5'd0, lu3[2:0]}, lh3);
    model_step(1, lv8, lu8, lh8);
  endtask

  // Assert reset now (inputs as currently driven), check outputs are forced low, release idle.
  task automatic pulse_reset();
    ARESETn = 1'b0;
    #1;
    chk("rst_n3_grant", 32'(G3), 32'd0);
    chk("rst_n3_id", 32'(ID3), 32'd0);
    chk("rst_n3_busy", 32'(B3), 32'd0);
    chk("rst_n8_grant", 32'(G8), 32'd0);
    chk("rst_n8_busy", 32'(B8), 32'd0);
    model_reset();
    @(negedge ACLK);
    V3 = '0; U3 = '0; HS3 = 1'b0;
    V8 = '0; U8 = '0; HS8 = 1'b0;
    ARESETn = 1'b1;
  endtask

  initial begin
    logic [7:0] rv3, ru3, rv8, ru8;
    logic rh3, rh8;
    ARESETn = 1'b0;
    V3 = 3'b111; U3 = '0; HS3 = 1'b0;
    V8 = 8'hff;  U8 = '0; HS8 = 1'b0;
    #3;
    pulse_reset();

    // Grant, lock, release, rotate
    cycle(8'h07, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'b001, -1);
    cycle(8'h07, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 3'b001, -1);
    cycle(8'h07, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'b010, -1);
    // Locked grant ignores request changes
    for (int k = 0; k < 4; k++)
      cycle(8'h05, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'b010, -1);
    cycle(8'h05, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 3'b010, -1);
    cycle(8'h07, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'b100, -1);
    cycle(8'h07, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 3'b100, -1);
    // Same-cycle handshake, pointer wraps to 0
    cycle(8'h04, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 3'b100, -1);
    cycle(8'h07, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'b001, -1);
    cycle(8'h07, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 3'b001, -1);
    // Eight masters: master 7 completes, pointer wraps
    cycle(8'h00, 8'h00, 1'b0, 8'h80, 8'h00, 1'b1, -1, 8'h80);
    cycle(8'h00, 8'h00, 1'b0, 8'h81, 8'h00, 1'b0, -1, 8'h01);
    cycle(8'h00, 8'h00, 1'b0, 8'h81, 8'h00, 1'b1, -1, 8'h01);
    // Reset while locked on master 2
    cycle(8'h04, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'b100, -1);
    @(negedge ACLK);
    V3 = 3'b111;
    pulse_reset();
    cycle(8'h06, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'b010, -1);
    @(negedge ACLK);
    pulse_reset();
    // Urgent override from ptr=0
`ifdef ARB_QOS_EN
    cycle(8'h07, 8'h04, 1'b0, 8'h00, 8'h00, 1'b0, 3'b100, -1);
`else
    cycle(8'h07, 8'h04, 1'b0, 8'h00, 8'h00, 1'b0, 3'b001, -1);
`endif

    for (int n = 0; n < 600; n++) begin
      rv3 = 8'($urandom) & ((n % 3 == 0) ? 8'($urandom) : 8'hff);
      ru3 = 8'($urandom);
      rv8 = 8'($urandom) & 8'($urandom);
      ru8 = 8'($urandom) & 8'($urandom);
      rh3 = ($urandom_range(0, 1) == 1) && (rv3[2:0] != 3'b000 || m_lk[0] != 0);
      rh8 = ($urandom_range(0, 2) == 0) && (rv8 != 8'h00 || m_lk[1] != 0);
      cycle(rv3, ru3, rh3, rv8, ru8, rh8, -1, -1);
      if (n % 150 == 149) begin
        @(negedge ACLK);
        pulse_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
